// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: FSM states, access size codes and
// read/write direction constants.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_F = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Access watchdog: counts GNT cycles since the last clear and flags the final
// allowed cycle so the arbiter can abort a hung access.
module arb_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at TIMEOUT so a missed clear can never wrap back into range.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data load/store,
// runs the MOV/MOC handshake for the granted side, aborts hung accesses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              f_req,
    input  logic [ADDR_W-1:0]                 f_addr,
    output logic                              f_moc,
    output logic [DATA_W-1:0]                 f_data,
    input  logic                              d_req,
    input  logic                              d_rw,
    input  logic [1:0]                        d_size,
    input  logic [ADDR_W-1:0]                 d_addr,
    input  logic [DATA_W-1:0]                 d_wdata,
    output logic                              d_moc,
    output logic [DATA_W-1:0]                 d_rdata,
    output logic                              mem_mov,
    output logic                              mem_rw,
    output logic [1:0]                        mem_size,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [DATA_W-1:0]                 mem_wdata,
    input  logic                              mem_moc,
    input  logic [DATA_W-1:0]                 mem_rdata,
    output logic                              err,
    output logic [1:0]                        dbg_state_o,
    output logic [$clog2(STARVE_LIMIT+1)-1:0] dbg_starve_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e        state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              own_data_q, own_data_d;
    logic              abort_q, abort_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wd_clr, wd_en, wd_tc;
    logic              starve_full;

    assign starve_full = (starve_q == SW'(STARVE_LIMIT));

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        own_data_d = own_data_q;
        abort_d    = abort_q;
        rdata_d    = rdata_q;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;
        case (state_q)
            IDLE: begin
                // Data wins ties unless fetch has already been passed over STARVE_LIMIT times.
                if (d_req && !(f_req && starve_full)) begin
                    state_d    = GNT_D;
                    own_data_d = 1'b1;
                    wd_clr     = 1'b1;
                    if (!f_req) begin
                        starve_d = '0;
                    end else if (!starve_full) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (f_req) begin
                    state_d    = GNT_F;
                    own_data_d = 1'b0;
                    wd_clr     = 1'b1;
                    starve_d   = '0;
                end else begin
                    starve_d = '0;
                end
            end
            GNT_F, GNT_D: begin
                wd_en = 1'b1;
                if (mem_moc) begin
                    state_d = DONE;
                    abort_d = 1'b0;
                    rdata_d = mem_rdata;
                end else if (wd_tc) begin
                    state_d = DONE;
                    abort_d = 1'b1;
                    rdata_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            own_data_q <= 1'b0;
            abort_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            own_data_q <= own_data_d;
            abort_q    <= abort_d;
            rdata_q    <= rdata_d;
        end
    end

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clr_i (wd_clr),
        .en_i  (wd_en),
        .tc_o  (wd_tc)
    );

    always_comb begin
        mem_mov   = 1'b0;
        mem_rw    = 1'b0;
        mem_size  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            GNT_F: begin
                mem_mov  = 1'b1;
                mem_rw   = RW_READ;
                mem_size = SZ_WORD;
                mem_addr = f_addr;
            end
            GNT_D: begin
                mem_mov   = 1'b1;
                mem_rw    = d_rw;
                mem_size  = d_size;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            default: begin
                mem_mov = 1'b0;
            end
        endcase
    end

    assign f_moc        = (state_q == DONE) && !own_data_q;
    assign d_moc        = (state_q == DONE) && own_data_q;
    assign err          = (state_q == DONE) && abort_q;
    assign f_data       = f_moc ? rdata_q : '0;
    assign d_rdata      = d_moc ? rdata_q : '0;
    assign dbg_state_o  = state_q;
    assign dbg_starve_o = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int ADDR_W       = 9;
    localparam int DATA_W       = 32;
    localparam int TIMEOUT      = 15;
    localparam int STARVE_LIMIT = 4;
    localparam int SW           = $clog2(STARVE_LIMIT + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              f_req = 1'b0;
    logic [ADDR_W-1:0] f_addr = '0;
    logic              f_moc;
    logic [DATA_W-1:0] f_data;
    logic              d_req = 1'b0;
    logic              d_rw = 1'b0;
    logic [1:0]        d_size = 2'b00;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_moc;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_mov;
    logic              mem_rw;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_moc = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              err;
    logic [1:0]        dbg_state;
    logic [SW-1:0]     dbg_starve;

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .TIMEOUT      (TIMEOUT),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .f_req        (f_req),
        .f_addr       (f_addr),
        .f_moc        (f_moc),
        .f_data       (f_data),
        .d_req        (d_req),
        .d_rw         (d_rw),
        .d_size       (d_size),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_moc        (d_moc),
        .d_rdata      (d_rdata),
        .mem_mov      (mem_mov),
        .mem_rw       (mem_rw),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_moc      (mem_moc),
        .mem_rdata    (mem_rdata),
        .err          (err),
        .dbg_state_o  (dbg_state),
        .dbg_starve_o (dbg_starve)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, need 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: 0 none, 1 fetch, 2 data; age = GNT cycles spent; done = completion cycle.
    int          m_owner  = 0;
    int          m_age    = 0;
    int          m_starve = 0;
    bit          m_done   = 1'b0;
    bit          m_abort  = 1'b0;
    bit          m_rw     = 1'b0;
    logic [31:0] m_data   = '0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_owner = 0; m_age = 0; m_starve = 0; m_done = 0; m_abort = 0; m_data = '0;
        end else if (m_done) begin
            m_done  = 0;
            m_owner = 0;
        end else if (m_owner != 0) begin
            m_age++;
            if (mem_moc) begin
                m_done = 1; m_abort = 0; m_data = mem_rdata;
            end else if (m_age == TIMEOUT) begin
                m_done = 1; m_abort = 1; m_data = '0;
            end
        end else begin
            if (d_req && !(f_req && m_starve == STARVE_LIMIT)) begin
                m_owner  = 2; m_age = 0; m_rw = d_rw;
                m_starve = f_req ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve) : 0;
            end else if (f_req) begin
                m_owner = 1; m_age = 0; m_rw = 1; m_starve = 0;
            end else begin
                m_starve = 0;
            end
        end
    end

    // ---------------- compare + moc monitor ----------------
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];
    int         got_t[$];
    int         gnt_cycles = 0;
    bit         exp_gnt;

    always @(negedge clk) begin
        #3;
        if (cmp_en) begin
            exp_gnt = (m_owner != 0) && !m_done;
            check("mem_mov", mem_mov, exp_gnt);
            if (exp_gnt && m_owner == 1) begin
                check("mem_rw_f", mem_rw, 1);
                check("mem_size_f", mem_size, 2'b10);
                check("mem_addr_f", mem_addr, f_addr);
            end else if (exp_gnt) begin
                check("mem_rw_d", mem_rw, d_rw);
                check("mem_size_d", mem_size, d_size);
                check("mem_addr_d", mem_addr, d_addr);
                if (!d_rw) check("mem_wdata_d", mem_wdata, d_wdata);
            end
            check("f_moc", f_moc, m_done && m_owner == 1);
            check("d_moc", d_moc, m_done && m_owner == 2);
            check("err", err, m_done && m_abort);
            if (m_done && (m_rw || m_abort)) begin
                if (m_owner == 1) check("f_data", f_data, m_data);
                else              check("d_rdata", d_rdata, m_data);
            end
            check("starve", dbg_starve, m_starve);
            if (f_moc) begin got_q.push_back(2'd1); got_t.push_back(cyc); end
            if (d_moc) begin got_q.push_back(2'd2); got_t.push_back(cyc); end
            if (mem_mov) gnt_cycles++;
        end
    end

    // ---------------- RAM responder ----------------
    // mem_delay = N > 0 raises mem_moc in the Nth GNT cycle; <= 0 never answers.
    int          mem_delay = 1;
    logic [31:0] resp_data = '0;
    bit          resp_en   = 1'b1;
    int          rcnt      = 0;

    always @(negedge clk) begin
        if (resp_en) begin
            if (mem_mov) begin
                rcnt++;
                if (mem_delay > 0 && rcnt == mem_delay) begin
                    mem_moc = 1'b1; mem_rdata = resp_data;
                end else begin
                    mem_moc = 1'b0; mem_rdata = '0;
                end
            end else begin
                rcnt = 0; mem_moc = 1'b0; mem_rdata = '0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_moc(input bit want_d, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #4;
            if (want_d ? d_moc : f_moc) ok = 1'b1;
        end
    endtask

    task automatic check_order(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(name, got_q[i], exp_q[i]);
    endtask

    // ---------------- directed scenarios ----------------
    bit ok;
    int t0;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        #4;
        check("rst_mem_mov", mem_mov, 0);
        check("rst_mem_rw", mem_rw, 0);
        check("rst_mem_size", mem_size, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mocs_err", {f_moc, d_moc, err}, 0);
        check("rst_data", f_data | d_rdata, 0);
        check("rst_state", dbg_state, IDLE);
        tick(1);
        reset = 1'b0;

        // stray mem_moc while idle
        tick(1);
        resp_en = 1'b0; mem_moc = 1'b1; mem_rdata = 32'h1234_5678;
        tick(1);
        mem_moc = 1'b0; mem_rdata = '0; resp_en = 1'b1;
        tick(2);
        check("stray_state", dbg_state, IDLE);
        check("stray_no_moc", got_q.size(), 0);

        // single fetch, RAM answers in 3rd GNT cycle
        got_q.delete(); got_t.delete(); gnt_cycles = 0;
        f_addr = 9'h010; mem_delay = 3; resp_data = 32'h8C22_0004;
        f_req = 1'b1; t0 = cyc;
        wait_moc(0, 40, ok);
        check("fetch_seen", ok, 1);
        check("fetch_data", f_data, 32'h8C22_0004);
        check("fetch_latency", got_t.size() > 0 ? got_t[0] - t0 : -1, 4);
        check("fetch_gnt_cycles", gnt_cycles, 3);
        f_req = 1'b0;

        // simultaneous requests: data byte write first, fetch after one idle cycle
        tick(1);
        got_q.delete(); got_t.delete();
        d_rw = RW_WRITE; d_size = SZ_BYTE; d_addr = 9'h040; d_wdata = 32'hDEAD_BEEF;
        f_addr = 9'h014; mem_delay = 1; resp_data = 32'h0000_0001;
        f_req = 1'b1; d_req = 1'b1;
        wait_moc(1, 40, ok);
        check("both_data_seen", ok, 1);
        d_req = 1'b0;
        wait_moc(0, 40, ok);
        check("both_fetch_seen", ok, 1);
        f_req = 1'b0;
        exp_q = '{2'd2, 2'd1};
        check_order("both_order");
        check("both_spacing", got_t.size() == 2 ? got_t[1] - got_t[0] : -1, 3);

        // data halfword read
        tick(1);
        d_rw = RW_READ; d_size = SZ_HALF; d_addr = 9'h102; mem_delay = 2; resp_data = 32'h0000_BEEF;
        d_req = 1'b1;
        wait_moc(1, 40, ok);
        check("read_seen", ok, 1);
        check("read_data", d_rdata, 32'h0000_BEEF);
        d_req = 1'b0;

        // starvation guard: both held, 4 data grants then fetch, then data resumes
        tick(1);
        got_q.delete(); got_t.delete();
        d_rw = RW_WRITE; d_size = SZ_WORD; d_addr = 9'h080; d_wdata = 32'hCAFE_0000;
        mem_delay = 1; f_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 120 && got_q.size() < 7; i++) begin
            @(negedge clk);
            #4;
            if (f_moc) f_req = 1'b0;
        end
        d_req = 1'b0; f_req = 1'b0;
        exp_q = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2};
        check_order("starve_order");
        check("starve_cleared", dbg_starve, 0);

        // watchdog: RAM never answers
        tick(2);
        got_q.delete(); gnt_cycles = 0;
        mem_delay = 0; d_rw = RW_READ; d_req = 1'b1;
        wait_moc(1, 40, ok);
        check("to_seen", ok, 1);
        check("to_err", err, 1);
        check("to_rdata", d_rdata, 0);
        check("to_mem_mov", mem_mov, 0);
        check("to_gnt_cycles", gnt_cycles, TIMEOUT);
        d_req = 1'b0;

        // reset in the middle of a data access
        tick(2);
        d_req = 1'b1;
        tick(4);
        check("mid_in_gnt", mem_mov, 1);
        reset = 1'b1; d_req = 1'b0;
        @(negedge clk);
        #4;
        check("mid_mem_mov", mem_mov, 0);
        check("mid_state", dbg_state, IDLE);
        check("mid_no_done", {d_moc, err}, 0);
        tick(1);
        reset = 1'b0; got_q.delete();
        tick(20);
        check("mid_no_moc_after", got_q.size(), 0);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
